serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
- Bit-serial adder/subtractor controller. Sequences a single 1-bit full-adder cell over WIDTH cycles to add or subtract two WIDTH-bit operands, LSB first.
- Provides a start/busy/done handshake and a committed result register.
- Serves as the area-minimal add path for the lab CPU datapath and as the sequencing harness for the 1-bit adder cell.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 2).
- CNT_W, $clog2(WIDTH), bit-index counter width.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- abort  in  1  synchronous cancel of an operation in progress.
- sub  in  1  0: a+b+cin; 1: a-b (a + ~b + 1), cin ignored.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- cin  in  1  carry-in for add, sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result commits.
- z  out  WIDTH  committed sum/difference.
- cout  out  1  committed carry-out (for sub: 1 = no borrow).
- ovf  out  1  committed signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n=0, immediate): state=IDLE, busy=0, done=0, z=0, cout=0, ovf=0, internal shift regs/counter/carry=0.
- FSM states:
  - IDLE
    - start=1 -> RUN.
    - Latch sa=a, sb=(sub ? ~b : b), carry=(sub ? 1 : cin), idx=0.
  - RUN
    - Each cycle the cell computes {c,s}=sa[0]+sb[0]+carry.
    - sa, sb shift right by 1; the result shift reg shifts right with s into MSB.
    - carry<=c, idx<=idx+1.
    - When idx==WIDTH-2, also record c as cmsb_in (carry into MSB).
    - On the edge where idx==WIDTH-1: commit z, cout=c, ovf=cmsb_in^c, then -> DONE.
  - DONE
    - done=1 for exactly this cycle.
    - start=1 -> RUN with a new latch (back-to-back).
    - Otherwise -> IDLE.
- Latency: start sampled at edge E0; last bit at edge E_WIDTH. done high in the cycle after E_WIDTH and z valid from then on. Throughput is one op per WIDTH+1 cycles.
- busy=1 exactly in RUN (WIDTH cycles).
- start in RUN is ignored (not queued).
- abort in RUN: -> IDLE next edge, no done pulse, z/cout/ovf keep their previous committed values.
- abort in IDLE/DONE: no effect; abort wins over start in DONE.
- Outputs z/cout/ovf change only on commit or reset and hold indefinitely otherwise.
- Counter never wraps; idx is reset on every start.
- Async reset mid-RUN: all state cleared immediately, no done.

Decomposition:
- Shared package serial_add_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - default WIDTH constant.
- One natural sub-module: serial_fa_cell (combinational 1-bit full adder; ports z, cout, a, b, cin), instantiated once. The control, shift registers and commit logic stay in serial_add_ctrl.

Test Plan:
- Reset mid-RUN (WIDTH=32): start a=5,b=3, assert rst_n=0 at cycle 10 -> busy=0, done=0, z=0 immediately; no done afterwards.
- Add: a=32'h0000_0005, b=32'h0000_0003, cin=1, sub=0 -> done exactly 32 cycles after the start edge, z=32'h9, cout=0, ovf=0; busy high for 32 cycles.
- Overflow/carry: a=32'h7FFF_FFFF, b=1 -> z=32'h8000_0000, cout=0, ovf=1. Then a=32'hFFFF_FFFF, b=1 -> z=0, cout=1, ovf=0.
- Subtract: a=10, b=3, sub=1, cin=0 -> z=7, cout=1. Then a=3, b=10 -> z=32'hFFFF_FFF9, cout=0, ovf=0.
- Back-to-back plus abort: start held in DONE with a=1,b=1 -> immediate re-entry to RUN, z=2. Abort at RUN cycle 5 of a third op -> no done, z stays 2.
- Exhaustive WIDTH=4: all a, b, cin, sub combinations -> z/cout/ovf match a reference model; start pulses during RUN are ignored.

Source files
------------

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared constants and state encoding for the bit-serial adder
package serial_add_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/serial_fa_cell.sv
// rtl/serial_fa_cell.sv - combinational 1-bit full adder cell
module serial_fa_cell (
  output logic z,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign z    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - sequences one full-adder cell over WIDTH cycles, LSB first
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic               cmsb_q, cmsb_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   z_q, z_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic fa_s;
  logic fa_c;
  logic launch;

  serial_fa_cell u_fa (
    .z   (fa_s),
    .cout(fa_c),
    .a   (sa_q[0]),
    .b   (sb_q[0]),
    .cin (carry_q)
  );

  // abort only blocks a restart out of DONE; from IDLE a start always launches
  assign launch = start && ((state_q == IDLE) || (state_q == DONE && !abort));

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    idx_d   = idx_q;
    z_d     = z_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (launch) begin
          sa_d    = a;
          sb_d    = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cmsb_d  = 1'b0;
          idx_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          sa_d    = sa_q >> 1;
          sb_d    = sb_q >> 1;
          res_d   = {fa_s, res_q[WIDTH-1:1]};
          carry_d = fa_c;
          if (idx_q == CNT_W'(WIDTH - 2)) begin
            cmsb_d = fa_c;
          end
          // the last bit commits straight from the cell, so the counter stops here
          if (idx_q == CNT_W'(WIDTH - 1)) begin
            z_d     = {fa_s, res_q[WIDTH-1:1]};
            cout_d  = fa_c;
            ovf_d   = cmsb_q ^ fa_c;
            state_d = DONE;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      idx_q   <= '0;
      z_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      idx_q   <= idx_d;
      z_q     <= z_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign z    = z_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
